// File: rtl/snax_tcdm_pkg.sv
// Shared types and helpers for the SNAX TCDM responder: request/response
// structs, index-width helpers and the byte-address to bank/row split.
package snax_tcdm_pkg;

  localparam int unsigned ByteOffset = 3;
  localparam int unsigned DataWidth  = 64;
  localparam int unsigned StrbWidth  = DataWidth / 8;
  localparam int unsigned AddrWidth  = 17;
  localparam int unsigned UserWidth  = 1;

  localparam int unsigned NumPortsDefault  = 16;
  localparam int unsigned NumBanksDefault  = 32;
  localparam int unsigned BankDepthDefault = 256;

  // Index width for n entries; never below one bit so ports stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BankIdxWidth = idx_width(NumBanksDefault);
  localparam int unsigned RowIdxWidth  = idx_width(BankDepthDefault);

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    amo_op_e              amo;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [UserWidth-1:0] user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    logic           p_valid;
    tcdm_rsp_chan_t p;
  } tcdm_rsp_t;

  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] row;
  } addr_split_t;

  // Word-interleaved split: low word bits pick the bank, the next bits pick
  // the row. Anything above bank*row capacity wraps.
  function automatic addr_split_t split_addr(input logic [AddrWidth-1:0] addr,
                                             input int unsigned num_banks,
                                             input int unsigned bank_depth);
    addr_split_t res;
    logic [31:0] word;
    word     = 32'(addr[AddrWidth-1:ByteOffset]);
    res.bank = word % num_banks;
    res.row  = (word / num_banks) % bank_depth;
    return res;
  endfunction

endpackage

// File: rtl/snax_tcdm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NumReq requesters, highest
// priority at the port after the previous winner.
module snax_tcdm_rr_arbiter
  import snax_tcdm_pkg::*;
#(
  parameter int unsigned NumReq = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o
);

  localparam int unsigned PtrW = idx_width(NumReq);

  logic [PtrW-1:0] ptr_q, ptr_d;

  // Scan requesters starting at the pointer; first hit wins and moves the pointer past it.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = (32'(ptr_q) + i) % NumReq;
      if (!found && req_i[PtrW'(idx)]) begin
        found              = 1'b1;
        gnt_o[PtrW'(idx)]  = 1'b1;
        ptr_d              = PtrW'((idx + 1) % NumReq);
      end
    end
  end

  // Priority pointer; only moves when something was granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/snax_tcdm_responder.sv
// Multi-bank TCDM responder: word-interleaved banks, per-bank round-robin
// arbitration, one-cycle read/write responses, conflict-cycle counter.
module snax_tcdm_responder
  import snax_tcdm_pkg::*;
#(
  parameter int unsigned NumPorts  = 16,
  parameter int unsigned NumBanks  = 32,
  parameter int unsigned BankDepth = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  tcdm_req_t   tcdm_req_i [NumPorts],
  output tcdm_rsp_t   tcdm_rsp_o [NumPorts],
  output logic [31:0] conflict_cnt_o
);

  localparam int unsigned BankW = idx_width(NumBanks);
  localparam int unsigned RowW  = idx_width(BankDepth);

  logic [NumPorts-1:0]                 port_valid;
  logic [NumPorts-1:0]                 port_write;
  logic [NumPorts-1:0]                 port_ready;
  addr_split_t                         port_split [NumPorts];
  logic [BankW-1:0]                    port_bank  [NumPorts];
  logic [RowW-1:0]                     port_row   [NumPorts];

  logic [NumBanks-1:0][NumPorts-1:0]   bank_req;
  logic [NumBanks-1:0][NumPorts-1:0]   bank_gnt;
  logic [NumBanks-1:0][DataWidth-1:0]  bank_rdata;

  logic [NumPorts-1:0]                 p_valid_q, p_valid_d;
  logic [DataWidth-1:0]                p_data_q [NumPorts];
  logic [DataWidth-1:0]                p_data_d [NumPorts];
  logic [31:0]                         conflict_cnt_q, conflict_cnt_d;

  // Decode each port's request into bank and row indices.
  always_comb begin
    port_valid = '0;
    port_write = '0;
    for (int p = 0; p < NumPorts; p++) begin
      port_split[p] = split_addr(tcdm_req_i[p].q.addr, NumBanks, BankDepth);
      port_valid[p] = tcdm_req_i[p].q_valid;
      port_write[p] = tcdm_req_i[p].q.write;
      port_bank[p]  = BankW'(port_split[p].bank);
      port_row[p]   = RowW'(port_split[p].row);
    end
  end

  // AMO opcode and user bits do not influence behaviour; high split bits are always zero.
  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port_unused
    logic unused_bits;
    assign unused_bits = ^{tcdm_req_i[gi].q.amo, tcdm_req_i[gi].q.user,
                           port_split[gi].bank[31:BankW], port_split[gi].row[31:RowW]};
  end

  // Build the per-bank request vectors.
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        bank_req[b][p] = port_valid[p] && (port_bank[p] == BankW'(b));
      end
    end
  end

  for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank
    logic [DataWidth-1:0] mem_q [BankDepth];
    logic                 bank_we;
    logic [RowW-1:0]      bank_row;
    logic [DataWidth-1:0] bank_wdata;
    logic [DataWidth-1:0] bank_merged;
    logic [StrbWidth-1:0] bank_strb;

    snax_tcdm_rr_arbiter #(
      .NumReq (NumPorts)
    ) i_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (bank_req[gi]),
      .gnt_o (bank_gnt[gi])
    );

    // Route the granted port's request onto this bank.
    always_comb begin
      bank_we    = 1'b0;
      bank_row   = '0;
      bank_wdata = '0;
      bank_strb  = '0;
      for (int p = 0; p < NumPorts; p++) begin
        if (bank_gnt[gi][p]) begin
          bank_we    = port_write[p];
          bank_row   = port_row[p];
          bank_wdata = tcdm_req_i[p].q.data;
          bank_strb  = tcdm_req_i[p].q.strb;
        end
      end
    end

    // Row content before this cycle's write gives read-before-write.
    assign bank_rdata[gi] = mem_q[bank_row];

    // Overlay strobed byte lanes on the current row content.
    always_comb begin
      bank_merged = bank_rdata[gi];
      for (int b = 0; b < StrbWidth; b++) begin
        if (bank_strb[b]) begin
          bank_merged[8*b +: 8] = bank_wdata[8*b +: 8];
        end
      end
    end

    // Bank storage; reset clears every row.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int r = 0; r < BankDepth; r++) begin
          mem_q[r] <= '0;
        end
      end else if (bank_we) begin
        mem_q[bank_row] <= bank_merged;
      end
    end
  end

  // Grant is the OR of all bank grants, forced low while in reset.
  always_comb begin
    port_ready = '0;
    for (int b = 0; b < NumBanks; b++) begin
      port_ready = port_ready | bank_gnt[b];
    end
    if (rst_i) begin
      port_ready = '0;
    end
  end

  // Next response: one p_valid per accepted request; writes return zero data.
  always_comb begin
    p_valid_d = port_ready;
    for (int p = 0; p < NumPorts; p++) begin
      p_data_d[p] = '0;
      if (port_ready[p] && !port_write[p]) begin
        p_data_d[p] = bank_rdata[port_bank[p]];
      end
    end
  end

  // Count cycles with at least one stalled request, saturating at all-ones.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (|(port_valid & ~port_ready) && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  // Response and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_valid_q      <= '0;
      conflict_cnt_q <= '0;
      for (int p = 0; p < NumPorts; p++) begin
        p_data_q[p] <= '0;
      end
    end else begin
      p_valid_q      <= p_valid_d;
      conflict_cnt_q <= conflict_cnt_d;
      for (int p = 0; p < NumPorts; p++) begin
        p_data_q[p] <= p_data_d[p];
      end
    end
  end

  // Pack the response structs.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      tcdm_rsp_o[p]         = '0;
      tcdm_rsp_o[p].q_ready = port_ready[p];
      tcdm_rsp_o[p].p_valid = p_valid_q[p];
      tcdm_rsp_o[p].p.data  = p_data_q[p];
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Directed bench for snax_tcdm_responder.
module tb_snax_tcdm_responder;
  import snax_tcdm_pkg::*;

  localparam int NP = 16;
  localparam int NB = 32;
  localparam int BD = 256;

  logic        clk = 1'b0;
  logic        rst;
  tcdm_req_t   req [NP];
  tcdm_rsp_t   rsp [NP];
  logic [31:0] conflict_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  snax_tcdm_responder #(
    .NumPorts  (NP),
    .NumBanks  (NB),
    .BankDepth (BD)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tcdm_req_i     (req),
    .tcdm_rsp_o     (rsp),
    .conflict_cnt_o (conflict_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ready_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[i] = rsp[i].q_ready;
    return v;
  endfunction

  function automatic logic [63:0] pvalid_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[i] = rsp[i].p_valid;
    return v;
  endfunction

  task automatic idle_all();
    for (int p = 0; p < NP; p++) req[p] = '0;
  endtask

  task automatic drive(input int p, input logic [AddrWidth-1:0] addr, input logic wr,
                       input logic [63:0] data, input logic [7:0] strb);
    req[p].q_valid = 1'b1;
    req[p].q.addr  = addr;
    req[p].q.write = wr;
    req[p].q.amo   = AMONone;
    req[p].q.data  = data;
    req[p].q.strb  = strb;
    req[p].q.user  = '0;
    $display("txn: port %0d %s addr 0x%0h data 0x%0h strb 0x%0h",
             p, wr ? "write" : "read", addr, data, strb);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_all();
    rst = 1'b1;

    // Reset state, with a request held during reset
    step();
    step();
    drive(0, 17'h0, 1'b0, '0, '0);
    #1;
    check_eq("rst_ready", ready_vec(), 64'h0);
    check_eq("rst_pvalid", pvalid_vec(), 64'h0);
    check_eq("rst_pdata", rsp[0].p.data, 64'h0);
    check_eq("rst_conflict", 64'(conflict_cnt), 64'h0);
    idle_all();
    step();
    rst = 1'b0;

    // Write then read back on port 0
    step();
    drive(0, 17'h8, 1'b1, 64'h1122334455667788, 8'hFF);
    #1;
    check_eq("t1_wr_ready", ready_vec(), 64'h1);
    check_eq("t1_wr_pvalid_pre", pvalid_vec(), 64'h0);
    step();
    drive(0, 17'h8, 1'b0, '0, '0);
    #1;
    check_eq("t1_rd_ready", ready_vec(), 64'h1);
    check_eq("t1_wr_pvalid", pvalid_vec(), 64'h1);
    check_eq("t1_wr_pdata", rsp[0].p.data, 64'h0);
    step();
    idle_all();
    #1;
    check_eq("t1_rd_pvalid", pvalid_vec(), 64'h1);
    check_eq("t1_rd_pdata", rsp[0].p.data, 64'h1122334455667788);
    check_eq("t1_idle_ready", ready_vec(), 64'h0);
    step();
    check_eq("t1_pvalid_drop", pvalid_vec(), 64'h0);

    // All 16 ports, distinct banks, single cycle
    for (int i = 0; i < NP; i++) drive(i, 17'(17'h100 + 8 * i), 1'b0, '0, '0);
    #1;
    check_eq("t2_ready_all", ready_vec(), 64'hFFFF);
    step();
    idle_all();
    #1;
    check_eq("t2_pvalid_all", pvalid_vec(), 64'hFFFF);
    check_eq("t2_pdata15", rsp[15].p.data, 64'h0);
    check_eq("t2_conflict", 64'(conflict_cnt), 64'h0);

    // Fresh arbiter state, then three ports fight for bank 0
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drive(0, 17'h0, 1'b0, '0, '0);
    drive(1, 17'h0, 1'b0, '0, '0);
    drive(2, 17'h0, 1'b0, '0, '0);
    #1;
    check_eq("t3_gnt_c1", ready_vec(), 64'h1);
    step();
    req[0] = '0;
    #1;
    check_eq("t3_gnt_c2", ready_vec(), 64'h2);
    check_eq("t3_pvalid_c2", pvalid_vec(), 64'h1);
    check_eq("t3_conflict_c2", 64'(conflict_cnt), 64'h1);
    step();
    req[1] = '0;
    #1;
    check_eq("t3_gnt_c3", ready_vec(), 64'h4);
    check_eq("t3_pvalid_c3", pvalid_vec(), 64'h2);
    step();
    idle_all();
    #1;
    check_eq("t3_pvalid_c4", pvalid_vec(), 64'h4);
    check_eq("t3_conflict_end", 64'(conflict_cnt), 64'h2);

    // Partial strobe and a zero-strobe write on port 3
    step();
    drive(3, 17'h40, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    #1;
    check_eq("t4_ready", ready_vec(), 64'h8);
    step();
    drive(3, 17'h40, 1'b1, 64'h0, 8'h0F);
    step();
    drive(3, 17'h40, 1'b1, 64'h1234, 8'h00);
    step();
    drive(3, 17'h40, 1'b0, '0, '0);
    #1;
    check_eq("t4_noop_pvalid", pvalid_vec(), 64'h8);
    check_eq("t4_noop_pdata", rsp[3].p.data, 64'h0);
    step();
    idle_all();
    #1;
    check_eq("t4_rd_pdata", rsp[3].p.data, 64'hFFFFFFFF00000000);

    // Aliasing: capacity is NB*BD*8 = 0x10000 bytes
    step();
    drive(7, 17'h10, 1'b1, 64'hAB, 8'hFF);
    step();
    drive(7, 17'h10010, 1'b0, '0, '0);
    step();
    idle_all();
    #1;
    check_eq("t5_alias_pvalid", pvalid_vec(), 64'h80);
    check_eq("t5_alias_pdata", rsp[7].p.data, 64'hAB);

    // Reset right after a read is accepted
    step();
    drive(5, 17'h10, 1'b0, '0, '0);
    #1;
    check_eq("t6_ready", ready_vec(), 64'h20);
    step();
    rst = 1'b1;
    #1;
    check_eq("t6_pvalid_rst", pvalid_vec(), 64'h0);
    check_eq("t6_pdata_rst", rsp[5].p.data, 64'h0);
    check_eq("t6_ready_rst", ready_vec(), 64'h0);
    step();
    idle_all();
    step();
    rst = 1'b0;
    #1;
    check_eq("t6_pvalid_rel", pvalid_vec(), 64'h0);
    step();
    check_eq("t6_pvalid_after", pvalid_vec(), 64'h0);
    drive(5, 17'h10, 1'b0, '0, '0);
    step();
    idle_all();
    #1;
    check_eq("t6_rd_pvalid", pvalid_vec(), 64'h20);
    check_eq("t6_rd_pdata", rsp[5].p.data, 64'h0);
    check_eq("t6_conflict", 64'(conflict_cnt), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
